// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game blocks.
// Holds screen geometry defaults, datapath widths and the paddle FSM state encoding.
// The state encoding doubles as the {right, left} "moving" output of paddle_motion.
package breakout_pkg;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned BORDER_WIDTH = 8;

  // Pixel coordinate width and the signed width used for clamp arithmetic
  localparam int unsigned PADDLE_X_W = 10;
  localparam int unsigned CLAMP_W    = PADDLE_X_W + 1;

  // Speed and frame counter width (both limited to 1..15)
  localparam int unsigned SPEED_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StMoveL = 2'b01,
    StMoveR = 2'b10
  } paddle_state_e;

endpackage

// File: rtl/paddle_speed_ramp.sv
// Paddle speed ramp: counts consecutive moving frames and raises the speed by one
// after every ACCEL_FRAMES of them, saturating at MAX_SPEED.
//
// Ports:
//   clk, nRst   - clock, asynchronous active-low reset
//   clr         - synchronous return to speed 1 / count 0 (recenter or idle frame)
//   restart     - this frame reverses or starts a move; use speed 1 / count 0 for it
//   adv         - a moving frame is being processed this cycle
//   clamped     - the move of this frame hit a wall
//   speed       - speed to apply for the current frame's move
module paddle_speed_ramp
  import breakout_pkg::*;
#(
  parameter int unsigned MAX_SPEED    = 4,
  parameter int unsigned ACCEL_FRAMES = 4
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               clr,
  input  logic               restart,
  input  logic               adv,
  input  logic               clamped,
  output logic [SPEED_W-1:0] speed
);

  logic [SPEED_W-1:0] speed_q, speed_d, speed_base;
  logic [SPEED_W-1:0] cnt_q, cnt_d, cnt_base;

  always_comb begin
    // A restart takes effect before the frame's move, so the move already sees speed 1
    speed_base = restart ? SPEED_W'(1) : speed_q;
    cnt_base   = restart ? '0 : cnt_q;
    speed_d    = speed_q;
    cnt_d      = cnt_q;
    if (clr) begin
      speed_d = SPEED_W'(1);
      cnt_d   = '0;
    end else if (adv) begin
      if (clamped) begin
        speed_d = SPEED_W'(1);
        cnt_d   = '0;
      end else if (cnt_base == SPEED_W'(ACCEL_FRAMES - 1)) begin
        cnt_d   = '0;
        speed_d = (speed_base >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                      : speed_base + SPEED_W'(1);
      end else begin
        cnt_d   = cnt_base + SPEED_W'(1);
        speed_d = speed_base;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      speed_q <= SPEED_W'(1);
      cnt_q   <= '0;
    end else begin
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign speed = speed_base;

endmodule

// File: rtl/paddle_motion.sv
// Breakout paddle motion controller. Once per video frame it reads the buttons,
// applies any latched shrink request, moves the paddle and clamps it to the walls.
// recenter restores the paddle immediately, independent of the frame timing.
//
// Ports:
//   clk, nRst     - clock, asynchronous active-low reset
//   frame_pulse   - one-cycle pulse per video frame
//   button_left   - level, move left
//   button_right  - level, move right
//   shrink        - one-cycle shrink request, applied at the next frame
//   recenter      - one-cycle request to restore width, position and speed
//   paddle_x      - left edge of the paddle (registered)
//   paddle_w      - current paddle width (registered)
//   moving        - {right, left} of the current FSM state (registered)
//
// Build option: define PADDLE_ACCEL_EN to enable the speed ramp (paddle_speed_ramp);
// otherwise the paddle always moves MAX_SPEED pixels per frame.
module paddle_motion #(
  parameter int unsigned SCREEN_W         = breakout_pkg::SCREEN_W,
  parameter int unsigned BORDER_WIDTH     = breakout_pkg::BORDER_WIDTH,
  parameter int unsigned PADDLE_WIDTH_MAX = 99,
  parameter int unsigned PADDLE_WIDTH_MIN = 49,
  parameter int unsigned MAX_SPEED        = 4,
  parameter int unsigned ACCEL_FRAMES     = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       frame_pulse,
  input  logic       button_left,
  input  logic       button_right,
  input  logic       shrink,
  input  logic       recenter,
  output logic [9:0] paddle_x,
  output logic [9:0] paddle_w,
  output logic [1:0] moving
);

  import breakout_pkg::*;

  localparam logic [PADDLE_X_W-1:0] CenterX = PADDLE_X_W'((SCREEN_W - PADDLE_WIDTH_MAX) >> 1);
  localparam logic [PADDLE_X_W-1:0] WidthMax = PADDLE_X_W'(PADDLE_WIDTH_MAX);
  localparam logic [PADDLE_X_W-1:0] WidthMin = PADDLE_X_W'(PADDLE_WIDTH_MIN);

  paddle_state_e           state_q, state_nxt;
  logic [PADDLE_X_W-1:0]   x_q, w_q;
  logic                    shrink_pend_q;

  logic [PADDLE_X_W-1:0]   x_sh, w_sh, x_mv;
  logic [SPEED_W-1:0]      speed;
  logic signed [CLAMP_W-1:0] x_s, tgt, lim_lo, lim_hi;
  logic                    move_en, clamped;

  // Shrink first (recentring the narrower paddle), then decode direction and move.
  always_comb begin
    x_sh = x_q;
    w_sh = w_q;
    if ((shrink_pend_q || shrink) && (w_q != WidthMin)) begin
      w_sh = WidthMin;
      x_sh = x_q + ((w_q - WidthMin) >> 1);
    end

    unique case ({button_right, button_left})
      2'b01:   state_nxt = StMoveL;
      2'b10:   state_nxt = StMoveR;
      default: state_nxt = StIdle;
    endcase
    move_en = (state_nxt != StIdle);

    // Signed arithmetic one bit wider than the coordinate so nothing wraps
    x_s    = signed'({1'b0, x_sh});
    lim_lo = signed'(CLAMP_W'(BORDER_WIDTH));
    lim_hi = signed'(CLAMP_W'(SCREEN_W - BORDER_WIDTH)) - signed'({1'b0, w_sh});
    unique case (state_nxt)
      StMoveL: tgt = x_s - signed'(CLAMP_W'(speed));
      StMoveR: tgt = x_s + signed'(CLAMP_W'(speed));
      default: tgt = x_s;
    endcase

    clamped = 1'b0;
    x_mv    = tgt[PADDLE_X_W-1:0];
    if (tgt < lim_lo) begin
      clamped = move_en;
      x_mv    = lim_lo[PADDLE_X_W-1:0];
    end else if (tgt > lim_hi) begin
      clamped = move_en;
      x_mv    = lim_hi[PADDLE_X_W-1:0];
    end
  end

`ifdef PADDLE_ACCEL_EN
  logic ramp_clr, ramp_restart, ramp_adv;

  assign ramp_clr     = recenter || (frame_pulse && !move_en);
  assign ramp_restart = move_en && (state_nxt != state_q);
  assign ramp_adv     = frame_pulse && move_en;

  paddle_speed_ramp #(
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_FRAMES(ACCEL_FRAMES)
  ) u_ramp (
    .clk    (clk),
    .nRst   (nRst),
    .clr    (ramp_clr),
    .restart(ramp_restart),
    .adv    (ramp_adv),
    .clamped(clamped),
    .speed  (speed)
  );
`else
  assign speed = SPEED_W'(MAX_SPEED);
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= StIdle;
      x_q           <= CenterX;
      w_q           <= WidthMax;
      shrink_pend_q <= 1'b0;
    end else if (recenter) begin
      state_q       <= StIdle;
      x_q           <= CenterX;
      w_q           <= WidthMax;
      shrink_pend_q <= 1'b0;
    end else if (frame_pulse) begin
      state_q       <= state_nxt;
      x_q           <= x_mv;
      w_q           <= w_sh;
      shrink_pend_q <= 1'b0;
    end else if (shrink) begin
      shrink_pend_q <= 1'b1;
    end
  end

  assign paddle_x = x_q;
  assign paddle_w = w_q;
  // State encoding is the {right, left} direction, so this stays a pure register output
  assign moving   = state_q;

endmodule

// File: tb/tb_paddle_motion.sv
module tb_paddle_motion;

  localparam int ScreenW = 640;
  localparam int Border  = 8;
  localparam int WMax    = 99;
  localparam int WMin    = 49;
  localparam int MaxSpd  = 4;
  localparam int AccFr   = 4;
`ifdef PADDLE_ACCEL_EN
  localparam bit Accel   = 1'b1;
`else
  localparam bit Accel   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       frame_pulse = 1'b0, button_left = 1'b0, button_right = 1'b0;
  logic       shrink = 1'b0, recenter = 1'b0;
  logic [9:0] paddle_x, paddle_w;
  logic [1:0] moving;

  paddle_motion dut (
    .clk         (clk),
    .nRst        (nRst),
    .frame_pulse (frame_pulse),
    .button_left (button_left),
    .button_right(button_right),
    .shrink      (shrink),
    .recenter    (recenter),
    .paddle_x    (paddle_x),
    .paddle_w    (paddle_w),
    .moving      (moving)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_x, m_w, m_spd, m_cnt, m_st, m_pend;

  typedef struct {int x; int w; int mv;} exp_t;
  exp_t sb_q[$];

  function automatic void model_reset();
    m_x = (ScreenW - WMax) / 2; m_w = WMax; m_spd = 1; m_cnt = 0; m_st = 0; m_pend = 0;
  endfunction

  function automatic void model_clock(input bit fp, l, r, sh, rc);
    int x, w, nst, step, tgt, lo, hi;
    bit clamp;
    if (rc) begin
      model_reset();
    end else if (fp) begin
      x = m_x; w = m_w;
      if ((m_pend != 0 || sh) && w != WMin) begin
        x = x + (w - WMin) / 2;
        w = WMin;
      end
      nst = (l && !r) ? 1 : (r && !l) ? 2 : 0;
      if (nst == 0 || nst != m_st) begin m_spd = 1; m_cnt = 0; end
      if (nst != 0) begin
        step = Accel ? m_spd : MaxSpd;
        tgt  = (nst == 1) ? x - step : x + step;
        lo = Border; hi = ScreenW - Border - w;
        clamp = 1'b0;
        if (tgt < lo) begin x = lo; clamp = 1'b1; end
        else if (tgt > hi) begin x = hi; clamp = 1'b1; end
        else x = tgt;
        if (clamp) begin m_spd = 1; m_cnt = 0; end
        else begin
          m_cnt++;
          if (m_cnt == AccFr) begin
            m_cnt = 0;
            if (m_spd < MaxSpd) m_spd++;
          end
        end
      end
      m_x = x; m_w = w; m_st = nst; m_pend = 0;
    end else if (sh) begin
      m_pend = 1;
    end
  endfunction

  // One clock: drive after the falling edge, model and push at the rising edge, check 1 ns later
  task automatic cyc(input string tag, input bit fp, l, r, sh, rc);
    exp_t e;
    @(negedge clk);
    frame_pulse = fp; button_left = l; button_right = r; shrink = sh; recenter = rc;
    @(posedge clk);
    model_clock(fp, l, r, sh, rc);
    sb_q.push_back('{x: m_x, w: m_w, mv: m_st});
    #1;
    e = sb_q.pop_front();
    check_eq({tag, ".x"}, int'(paddle_x), e.x);
    check_eq({tag, ".w"}, int'(paddle_w), e.w);
    check_eq({tag, ".mv"}, int'(moving), e.mv);
  endtask

  task automatic frames(input string tag, input int n, input bit l, r);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b1, l, r, 1'b0, 1'b0);
      cyc(tag, 1'b0, l, r, 1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("reset.x", int'(paddle_x), 270);
    check_eq("reset.w", int'(paddle_w), 99);
    check_eq("reset.mv", int'(moving), 0);
    nRst = 1'b1;

    // Ramp (or constant speed) to the right for 16 frames
    frames("right16", 16, 1'b0, 1'b1);
    check_eq("right16.final", int'(paddle_x), Accel ? 310 : 334);

    cyc("rc1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frames("left3", 3, 1'b1, 1'b0);
    check_eq("left3.final", int'(paddle_x), Accel ? 267 : 258);
    check_eq("left3.mv", int'(moving), 1);

    // Both buttons: idle, no motion
    frames("both", 2, 1'b1, 1'b1);
    check_eq("both.x", int'(paddle_x), Accel ? 267 : 258);
    check_eq("both.mv", int'(moving), 0);

    // Right wall, then stays there
    frames("rclamp", 90, 1'b0, 1'b1);
    check_eq("rclamp.x", int'(paddle_x), 533);
    frames("rhold", 3, 1'b0, 1'b1);
    check_eq("rhold.x", int'(paddle_x), 533);
    check_eq("rhold.mv", int'(moving), 2);

    // Left wall
    frames("lclamp", 160, 1'b1, 1'b0);
    check_eq("lclamp.x", int'(paddle_x), 8);
    check_eq("lclamp.mv", int'(moving), 1);

    // Shrink from the centred paddle; second shrink is a no-op
    cyc("rc2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("shr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("shr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("shr.pending_w", int'(paddle_w), 99);
    cyc("shr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("shr.w", int'(paddle_w), 49);
    check_eq("shr.x", int'(paddle_x), 295);
    cyc("shr2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("shr2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("shr2.w", int'(paddle_w), 49);
    check_eq("shr2.x", int'(paddle_x), 295);

    // Recenter beats shrink and frame in the same cycle
    cyc("conf", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("conf.x", int'(paddle_x), 270);
    check_eq("conf.w", int'(paddle_w), 99);

    // Reset between frames drops a pending shrink
    cyc("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    shrink = 1'b0;
    #2 nRst = 1'b0;
    model_reset();
    #2 nRst = 1'b1;
    cyc("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst.w", int'(paddle_w), 99);
    check_eq("rst.x", int'(paddle_x), 270);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
